// File: rtl/rr4_mux_arbiter_pkg.sv
// Shared definitions for the four-source round-robin mux arbiter:
// FSM state encoding and requester index constants.
package rr4_mux_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    localparam logic [1:0] SRC_A = 2'd0;
    localparam logic [1:0] SRC_B = 2'd1;
    localparam logic [1:0] SRC_C = 2'd2;
    localparam logic [1:0] SRC_D = 2'd3;

endpackage

// File: rtl/rr4_mux_arbiter_mux.sv
// Plain n-bit 4-to-1 multiplexer; S selects A/B/C/D for indices 0..3.
module nbit4x1Multiplexer #(
    parameter int n = 8
) (
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic [n-1:0] C,
    input  logic [n-1:0] D,
    input  logic [1:0]   S,
    output logic [n-1:0] Y
);

    always_comb begin
        case (S)
            2'd0:    Y = A;
            2'd1:    Y = B;
            2'd2:    Y = C;
            default: Y = D;
        endcase
    end

endmodule

// File: rtl/rr4_mux_arbiter.sv
// Round-robin arbiter sharing one 4-to-1 mux among four requesters, with a
// registered valid/ready output stage and a one-hot ack pulse on transfer.
module rr4_mux_arbiter
    import rr4_mux_arbiter_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic [n-1:0] C,
    input  logic [n-1:0] D,
    output logic [3:0]   ack,
    output logic [1:0]   S,
    output logic [n-1:0] Y,
    output logic         out_valid,
    input  logic         out_ready
);

    arb_state_e   state_q, state_d;
    logic [1:0]   ptr_q, ptr_d;
    logic [1:0]   s_q, s_d;
    logic [n-1:0] y_q, y_d;

    logic         grant_vld;
    logic [1:0]   grant_idx;
    logic [1:0]   mux_sel;
    logic [n-1:0] mux_y;
    logic [2:0]   pick;

    // Returns {found, index} of the first set bit searching start, start+1, ... mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // Grant selection: in HOLD the current source is masked so a stale req
    // during its own ack cycle cannot win again.
    always_comb begin
        ack  = 4'b0000;
        pick = 3'b000;
        case (state_q)
            IDLE: pick = rr_pick(req, ptr_q);
            HOLD: begin
                if (out_ready) begin
                    ack[s_q] = 1'b1;
                    pick     = rr_pick(req & ~(4'b0001 << s_q), s_q + 2'd1);
                end
            end
            default: pick = 3'b000;
        endcase
        grant_vld = pick[2];
        grant_idx = pick[1:0];
        mux_sel   = grant_vld ? grant_idx : s_q;
    end

    nbit4x1Multiplexer #(.n(n)) u_mux (
        .A (A),
        .B (B),
        .C (C),
        .D (D),
        .S (mux_sel),
        .Y (mux_y)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        s_d     = s_q;
        y_d     = y_q;
        if (state_q == HOLD && out_ready) begin
            ptr_d   = s_q + 2'd1;
            state_d = IDLE;
        end
        if (grant_vld) begin
            s_d     = grant_idx;
            y_d     = mux_y;
            state_d = HOLD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= SRC_A;
            s_q     <= SRC_A;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            s_q     <= s_d;
            y_q     <= y_d;
        end
    end

    assign S         = s_q;
    assign Y         = y_q;
    assign out_valid = (state_q == HOLD);

endmodule
